// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the register file with scoreboard.
package regfile_pkg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);

  // Architectural zero register (XZR): reads as zero, writes discarded.
  localparam logic [AW-1:0] ZERO_REG = 5'd31;

  typedef logic [WIDTH-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard_reg64_en.sv
// WIDTH-wide enabled D-flop register with asynchronous active-low clear.
module reg64_en
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en_i,
  input  word_t d_i,
  output word_t q_o
);

  word_t data_q;

  // Capture d_i when enabled; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {WIDTH{1'b0}};
    end else if (en_i) begin
      data_q <= d_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign q_o = data_q;

endmodule : reg64_en

// File: rtl/regfile_scoreboard.sv
// 32 x 64-bit integer register file: two bypassed read ports, one
// write-back port, XZR at index 31, and a busy-bit scoreboard that
// stalls decode while a source operand still has a producer in flight.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output word_t         rd_data_a,
  output word_t         rd_data_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  word_t         wr_data,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  output logic          stall
);

  logic [NREGS-1:0] we_s;
  word_t            regs_s [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             byp_a_s;
  logic             byp_b_s;

  // Write decoder: one-hot enable for the addressed register, none for XZR.
  always_comb begin
    we_s = {NREGS{1'b0}};
    if (wr_en && (wr_addr != ZERO_REG)) begin
      we_s[wr_addr] = 1'b1;
    end else begin
      we_s = {NREGS{1'b0}};
    end
  end

  // Storage for X0..X30; XZR has no flops and is tied to zero.
  for (genvar gi = 0; gi < NREGS - 1; gi++) begin : g_regs
    reg64_en u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (we_s[gi]),
      .d_i   (wr_data),
      .q_o   (regs_s[gi])
    );
  end
  assign regs_s[NREGS-1] = {WIDTH{1'b0}};

  assign byp_a_s = wr_en && (wr_addr == rd_addr_a);
  assign byp_b_s = wr_en && (wr_addr == rd_addr_b);

  // Read port A: zero register first, then same-cycle write-back bypass, then storage.
  always_comb begin
    rd_data_a = {WIDTH{1'b0}};
    if (rd_addr_a == ZERO_REG) begin
      rd_data_a = {WIDTH{1'b0}};
    end else if (byp_a_s) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs_s[rd_addr_a];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rd_data_b = {WIDTH{1'b0}};
    if (rd_addr_b == ZERO_REG) begin
      rd_data_b = {WIDTH{1'b0}};
    end else if (byp_b_s) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs_s[rd_addr_b];
    end
  end

  // Scoreboard next state: write-back clears, then issue sets so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end else begin
      busy_d[iss_addr] = busy_d[iss_addr];
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Scoreboard state; cleared asynchronously so stall drops at once in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= {NREGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Stall when a source is pending and its producer is not retiring this cycle.
  always_comb begin
    stall = 1'b0;
    if ((busy_q[rd_addr_a] && !byp_a_s) || (busy_q[rd_addr_b] && !byp_b_s)) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
  end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  word_t         rd_data_a;
  word_t         rd_data_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  word_t         wr_data;
  logic          iss_en;
  logic [AW-1:0] iss_addr;
  logic          stall;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    word_t         wr_data;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    word_t         exp_a;
    word_t         exp_b;
    logic          exp_stall;
  } vec_t;

  vec_t vecs[$];

  regfile_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check64(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [AW-1:0] wa, input word_t wd,
                     input logic ie, input logic [AW-1:0] ia,
                     input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                     input word_t ea, input word_t eb, input logic es);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.iss_en = ie; v.iss_addr = ia; v.ra = ra; v.rb = rb;
    v.exp_a = ea; v.exp_b = eb; v.exp_stall = es;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 64'h0;
    iss_en = 1'b0; iss_addr = 5'd0;
  endtask

  initial begin
    // Vectors: inputs driven on the falling edge, outputs checked before the next rising edge.
    //  wr  waddr  wdata                    iss iaddr ra     rb     exp_a                    exp_b                   stall
    add(1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 1'b0, 5'd0,  5'd5,  5'd31, 64'hDEAD_BEEF_0123_4567, 64'h0,                  1'b0);
    add(1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd5,  5'd31, 64'hDEAD_BEEF_0123_4567, 64'h0,                  1'b0);
    add(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0,  5'd31, 5'd5,  64'h0,                   64'hDEAD_BEEF_0123_4567, 1'b0);
    add(1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd31, 5'd0,  64'h0,                   64'h0,                  1'b0);
    add(1'b1, 5'd7,  64'h55,                  1'b0, 5'd0,  5'd7,  5'd7,  64'h55,                  64'h55,                 1'b0);
    add(1'b0, 5'd0,  64'h0,                   1'b1, 5'd3,  5'd7,  5'd3,  64'h55,                  64'h0,                  1'b0);
    add(1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd0,  5'd3,  64'h0,                   64'h0,                  1'b1);
    add(1'b1, 5'd3,  64'h33,                  1'b0, 5'd0,  5'd0,  5'd3,  64'h0,                   64'h33,                 1'b0);
    add(1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd0,  5'd3,  64'h0,                   64'h33,                 1'b0);
    add(1'b1, 5'd3,  64'h44,                  1'b1, 5'd3,  5'd3,  5'd7,  64'h44,                  64'h55,                 1'b0);
    add(1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd3,  5'd7,  64'h44,                  64'h55,                 1'b1);
    add(1'b1, 5'd3,  64'h45,                  1'b0, 5'd0,  5'd3,  5'd7,  64'h45,                  64'h55,                 1'b0);
    add(1'b1, 5'd10, 64'h0A,                  1'b0, 5'd0,  5'd10, 5'd3,  64'h0A,                  64'h45,                 1'b0);
    add(1'b0, 5'd0,  64'h0,                   1'b1, 5'd31, 5'd31, 5'd31, 64'h0,                   64'h0,                  1'b0);
    add(1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd31, 5'd31, 64'h0,                   64'h0,                  1'b0);
    add(1'b1, 5'd9,  64'h1,                   1'b1, 5'd9,  5'd9,  5'd10, 64'h1,                   64'h0A,                 1'b0);
    add(1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  5'd10, 5'd9,  64'h0A,                  64'h1,                  1'b1);

    // Reset.
    rst_n = 1'b0;
    idle_inputs();
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    #1;
    check1("stall_in_reset", stall, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Every index reads zero on both ports after reset, no stall.
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clk);
      rd_addr_a = i[AW-1:0];
      rd_addr_b = 5'(NREGS - 1 - i);
      #1;
      check64($sformatf("reset_a[%0d]", i), rd_data_a, 64'h0);
      check64($sformatf("reset_b[%0d]", NREGS - 1 - i), rd_data_b, 64'h0);
      check1($sformatf("reset_stall[%0d]", i), stall, 1'b0);
    end

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      #1;
      check64($sformatf("vec%0d_a", i), rd_data_a, vecs[i].exp_a);
      check64($sformatf("vec%0d_b", i), rd_data_b, vecs[i].exp_b);
      check1($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
    end

    // Async reset between edges while X9=1 and busy[9]=1, with a write in flight to X5.
    @(negedge clk);
    idle_inputs();
    rd_addr_a = 5'd9; rd_addr_b = 5'd0;
    #1;
    check64("pre_rst_x9", rd_data_a, 64'h1);
    check1("pre_rst_stall", stall, 1'b1);
    #1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h77;
    rst_n = 1'b0;
    #1;
    wr_en = 1'b0;
    #1;
    check64("async_rst_x9", rd_data_a, 64'h0);
    check1("async_rst_stall", stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_addr_a = 5'd5; rd_addr_b = 5'd9;
    #1;
    check64("post_rst_x5_lost", rd_data_a, 64'h0);
    check64("post_rst_x9", rd_data_b, 64'h0);
    check1("post_rst_stall", stall, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_regfile_scoreboard
